mult_div_unit: RTL and testbench

Parametrised sequential multiply/divide unit for the multi-cycle MIPS datapath. It is the successor to the shift-add multiplier, extended to signed and unsigned MULT and DIV. It returns results in HI/LO form and signals completion with a one-cycle valid pulse. It iterates one bit per clock, giving a fixed, operation-independent latency so the control FSM can rely on it.

---
 rtl/mult_div_if.sv | 24 ++
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the control FSM and the multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] Operand1;
    logic [DATA_WIDTH-1:0] Operand2;
    logic                  busy;
    logic                  valid;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  div_by_zero;

    modport master (
        output start, op, Operand1, Operand2,
        input  busy, valid, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, Operand1, Operand2,
        output busy, valid, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed/unsigned multiply and restoring divide, one bit per clock, HI/LO results.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic       CLK,
    input  logic       RST,
    mult_div_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_is_div;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_dz;
    logic [W-1:0]    r_m;
    logic [W-1:0]    r_a_raw;
    logic [W2-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;

    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_busy;
    logic            r_valid;
    logic            r_dz_out;

    logic            w_busy_nxt;
    logic            w_valid_nxt;
    logic            w_dz_nxt;
    logic [W-1:0]    w_hi_nxt;
    logic [W-1:0]    w_lo_nxt;

    // Operand conditioning at accept: magnitudes for signed ops, raw bits otherwise.
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;

    assign w_a_neg = bus.op[0] & bus.Operand1[W-1];
    assign w_b_neg = bus.op[0] & bus.Operand2[W-1];
    assign w_a_mag = w_a_neg ? W'(-bus.Operand1) : bus.Operand1;
    assign w_b_mag = w_b_neg ? W'(-bus.Operand2) : bus.Operand2;

    // One shift-add step: add multiplicand to the upper half when the low bit is set, then shift right.
    logic [W:0]      w_mul_sum;
    logic [W2:0]     w_mul_wide;
    logic [W2-1:0]   w_mul_nxt;

    assign w_mul_sum  = {1'b0, r_acc[W2-1:W]} + {1'b0, (r_acc[0] ? r_m : W'(0))};
    assign w_mul_wide = {w_mul_sum, r_acc[W-1:0]};
    assign w_mul_nxt  = w_mul_wide[W2:1];

    // One restoring-divide step: shift {rem,quo} left, keep the trial subtraction when non-negative.
    logic [W2:0]     w_div_shift;
    logic [W:0]      w_trial;
    logic [W2-1:0]   w_div_nxt;

    assign w_div_shift = {r_acc, 1'b0};
    assign w_trial     = w_div_shift[W2:W] - {1'b0, r_m};
    assign w_div_nxt   = w_trial[W] ? w_div_shift[W2-1:0]
                                    : ({w_trial[W-1:0], w_div_shift[W-1:0]} | W2'(1));

    // Sign fix-ups applied to the finished accumulator.
    logic [W2-1:0]   w_prod;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;

    assign w_prod = r_neg_res ? W2'(-r_acc) : r_acc;
    assign w_quo  = r_neg_res ? W'(-r_acc[W-1:0]) : r_acc[W-1:0];
    assign w_rem  = r_neg_rem ? W'(-r_acc[W2-1:W]) : r_acc[W2-1:W];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: W iterations in CALC, then a single DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_busy_nxt  = r_busy;
        w_valid_nxt = 1'b0;
        w_dz_nxt    = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: if (bus.start) w_busy_nxt = 1'b1;
            S_CALC: w_busy_nxt = 1'b1;
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b1;
                w_dz_nxt    = r_dz;
                if (r_dz) begin
                    w_hi_nxt = r_a_raw;
                    w_lo_nxt = '1;
                end else if (r_is_div) begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quo;
                end else begin
                    {w_hi_nxt, w_lo_nxt} = w_prod;
                end
            end
            default: w_busy_nxt = 1'b0;
        endcase
    end

    // Datapath: latch operands on accept, iterate while in CALC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_m       <= '0;
            r_a_raw   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_is_div  <= bus.op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz      <= bus.op[1] & (bus.Operand2 == W'(0));
            r_m       <= bus.op[1] ? w_b_mag : w_a_mag;
            r_a_raw   <= bus.Operand1;
            r_acc     <= {W'(0), (bus.op[1] ? w_a_mag : w_b_mag)};
            r_cnt     <= CW'(W);
        end else if (r_state == S_CALC) begin
            r_acc     <= r_is_div ? w_div_nxt : w_mul_nxt;
            r_cnt     <= r_cnt - CW'(1);
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_dz_out <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_valid  <= w_valid_nxt;
            r_dz_out <= w_dz_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.valid       = r_valid;
    assign bus.div_by_zero = r_dz_out;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops and compares on valid.
module tb_mult_div_unit;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_if #(.DATA_WIDTH(W)) bus ();
    mult_div_unit #(.DATA_WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint          sa, sbv, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [2*W-1:0]  pb;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dz = 1'b0;
        e.due = 0;
        case (op)
            2'b00: begin up = ua * ub; pb = up[2*W-1:0]; {e.hi, e.lo} = pb; end
            2'b01: begin sp = sa * sbv; pb = sp[2*W-1:0]; {e.hi, e.lo} = pb; end
            2'b10: begin
                if (ub == 0) begin e.dz = 1'b1; e.lo = '1; e.hi = a; end
                else begin up = ua / ub; e.lo = up[W-1:0]; up = ua % ub; e.hi = up[W-1:0]; end
            end
            default: begin
                if (sbv == 0) begin e.dz = 1'b1; e.lo = '1; e.hi = a; end
                else begin sq = sa / sbv; sr = sa % sbv; e.lo = sq[W-1:0]; e.hi = sr[W-1:0]; end
            end
        endcase
        return e;
    endfunction

    // Monitor: compare each valid pulse against the oldest expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("hi", 64'(bus.hi), 64'(e.hi));
                    chk("lo", 64'(bus.lo), 64'(e.lo));
                    chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
                    chk("busy_in_valid", 64'(bus.busy), 64'(0));
                end
            end else begin
                chk("dz_without_valid", 64'(bus.div_by_zero), 64'(0));
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_valid actual=none expected_at=%0d (cycle %0d)", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   guard;
        exp_t e;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.busy && guard < 100);
        if (bus.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_wait actual=busy expected=idle (cycle %0d)", cyc);
            return;
        end
        bus.start    = 1'b1;
        bus.op       = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        e     = model(op, a, b);
        e.due = cyc + W + 2;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'(1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a, b;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.Operand1 = '0;
        bus.Operand2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_valid", 64'(bus.valid), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        chk("rst_dz", 64'(bus.div_by_zero), 64'(0));
        rst = 1'b0;

        // MULTU 11 x 14 with busy observed through the whole operation.
        issue(2'b00, 5'b01011, 5'b01110);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_during_op", 64'(bus.busy), 64'(1));
        end
        drain();

        // Directed signed/divide cases, issued back to back (each start lands in the prior valid cycle).
        issue(2'b01, 5'b11101, 5'b00101);
        issue(2'b01, 5'b11101, 5'b11011);
        issue(2'b11, 5'b11001, 5'b00010);
        issue(2'b10, 5'b10111, 5'b00100);
        issue(2'b11, 5'b10000, 5'b11111);
        issue(2'b10, 5'b00111, 5'b00000);
        issue(2'b11, 5'b10011, 5'b00000);
        drain();

        // start held high with different operands while busy must not disturb the op in flight.
        issue(2'b01, 5'b10110, 5'b01101);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start    = 1'b1;
            bus.op       = 2'($urandom_range(0, 3));
            bus.Operand1 = W'($urandom);
            bus.Operand2 = W'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Reset three cycles into a MULT aborts it silently.
        issue(2'b01, 5'b10101, 5'b01011);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_hi", 64'(bus.hi), 64'(0));
        chk("abort_lo", 64'(bus.lo), 64'(0));
        chk("abort_valid", 64'(bus.valid), 64'(0));
        rst = 1'b0;
        repeat (W + 6) @(negedge clk);

        // Randomized mix with biased corner operands.
        for (int n = 0; n < 60; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = {1'b1, {(W-1){1'b0}}};
                2: b = '1;
                3: a = '1;
                default: ;
            endcase
            issue(2'($urandom_range(0, 3)), a, b);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
